// File: rtl/caixa_pkg.sv
// caixa_pkg: shared types and default constants for the water tank plant model
package caixa_pkg;
  typedef enum logic [1:0] {ESTAVEL, ENCHENDO, ESVAZIANDO, TRANSBORDO} estado_t;
  localparam logic [1:0] FALHA_NORMAL = 2'b00;
  localparam logic [1:0] FALHA_MEDIA0 = 2'b01;
  localparam logic [1:0] FALHA_ALTA1  = 2'b10;
  localparam logic [1:0] FALHA_TODOS0 = 2'b11;
  localparam int DEF_LEVEL_W    = 8;
  localparam int DEF_CAPACITY   = 100;
  localparam int DEF_INIT_LEVEL = 0;
  localparam int DEF_LOW_TH     = 20;
  localparam int DEF_MID_TH     = 50;
  localparam int DEF_HIGH_TH    = 80;
  localparam int DEF_FILL_RATE  = 4;
  localparam int DEF_DRIP_RATE  = 1;
  localparam int DEF_SPRAY_RATE = 3;
  localparam int DEF_TICK_DIV   = 10;
endpackage

// File: rtl/caixa_agua_planta_tick_gen.sv
// tick_gen: prescaler producing a one-clk tick every TICK_DIV cycles
module tick_gen #(
  parameter int TICK_DIV = 10
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);
  localparam int CW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
  logic [CW-1:0] cnt_q, cnt_d;
  assign tick  = cnt_q == CW'(TICK_DIV - 1);
  assign cnt_d = tick ? '0 : cnt_q + 1'b1;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
endmodule

// File: rtl/caixa_agua_planta.sv
// caixa_agua_planta: behavioural tank/irrigation plant closing the controller loop.
// Define CAIXA_FALHA_SENSOR_EN to add falha_sel sensor fault injection.
module caixa_agua_planta
  import caixa_pkg::*;
#(
  parameter int LEVEL_W    = DEF_LEVEL_W,
  parameter int CAPACITY   = DEF_CAPACITY,
  parameter int INIT_LEVEL = DEF_INIT_LEVEL,
  parameter int LOW_TH     = DEF_LOW_TH,
  parameter int MID_TH     = DEF_MID_TH,
  parameter int HIGH_TH    = DEF_HIGH_TH,
  parameter int FILL_RATE  = DEF_FILL_RATE,
  parameter int DRIP_RATE  = DEF_DRIP_RATE,
  parameter int SPRAY_RATE = DEF_SPRAY_RATE,
  parameter int TICK_DIV   = DEF_TICK_DIV
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               Ve,
  input  logic               Gotejamento,
  input  logic               Aspersao,
`ifdef CAIXA_FALHA_SENSOR_EN
  input  logic [1:0]         falha_sel,
`endif
  output logic               Alta,
  output logic               Media,
  output logic               Baixa,
  output logic [LEVEL_W-1:0] nivel,
  output logic [1:0]         estado,
  output logic               transbordo,
  output logic               seco
);
  localparam int NW = LEVEL_W + 2;
  if (!(LOW_TH <= MID_TH && MID_TH <= HIGH_TH && HIGH_TH <= CAPACITY &&
        CAPACITY < (1 << LEVEL_W) && INIT_LEVEL <= CAPACITY)) begin : g_bad_params
    $error("caixa_agua_planta: illegal threshold/capacity parameters");
  end
  logic tick;
  tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (.clk(clk), .rst_n(rst_n), .tick(tick));
  logic [LEVEL_W-1:0] level_q, level_d;
  estado_t            estado_q, estado_d;
  logic               transbordo_q, transbordo_d, seco_q, seco_d;
  logic [2:0]         sens_q, sens_d, raw;
  logic signed [NW-1:0] add, sub, nxt;
  logic over, under;
  assign add   = Ve ? NW'(FILL_RATE) : '0;
  assign sub   = (Gotejamento ? NW'(DRIP_RATE) : '0) + (Aspersao ? NW'(SPRAY_RATE) : '0);
  assign nxt   = $signed({2'b00, level_q}) + add - sub;
  assign over  = nxt > $signed(NW'(CAPACITY));
  assign under = nxt < 0;
  // sensors sample the level register, giving one clk of latency
  assign raw   = {level_q >= LEVEL_W'(HIGH_TH), level_q >= LEVEL_W'(MID_TH), level_q >= LEVEL_W'(LOW_TH)};
  always_comb begin
    level_d      = !tick ? level_q : over ? LEVEL_W'(CAPACITY) : under ? '0 : nxt[LEVEL_W-1:0];
    estado_d     = !tick ? estado_q : over ? TRANSBORDO : under ? ESTAVEL :
                   add > sub ? ENCHENDO : add < sub ? ESVAZIANDO : ESTAVEL;
    transbordo_d = tick & over;
    seco_d       = tick & under;
`ifdef CAIXA_FALHA_SENSOR_EN
    sens_d = falha_sel == FALHA_MEDIA0 ? {raw[2], 1'b0, raw[0]} :
             falha_sel == FALHA_ALTA1  ? {1'b1, raw[1:0]} :
             falha_sel == FALHA_TODOS0 ? 3'b000 : raw;
`else
    sens_d = raw;
`endif
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      level_q      <= LEVEL_W'(INIT_LEVEL);
      estado_q     <= ESTAVEL;
      transbordo_q <= 1'b0;
      seco_q       <= 1'b0;
      sens_q       <= '0;
    end else begin
      level_q      <= level_d;
      estado_q     <= estado_d;
      transbordo_q <= transbordo_d;
      seco_q       <= seco_d;
      sens_q       <= sens_d;
    end
  assign {Alta, Media, Baixa} = sens_q;
  assign nivel      = level_q;
  assign estado     = estado_q;
  assign transbordo = transbordo_q;
  assign seco       = seco_q;
endmodule

// File: tb/tb_caixa_agua_planta.sv
// tb_caixa_agua_planta: random and directed stimulus checked against a tick-level tank model
module tb_caixa_agua_planta;
  import caixa_pkg::*;
  localparam int TD = 10, CAP = 100, INIT = 0;
  logic clk = 0, rst_n = 0, ve = 0, got = 0, asp = 0;
  logic alta, media, baixa, transbordo, seco;
  logic [7:0] nivel;
  logic [1:0] estado;
`ifdef CAIXA_FALHA_SENSOR_EN
  logic [1:0] falha_sel = 2'b00;
`endif
  always #5 clk = ~clk;
  caixa_agua_planta dut (
    .clk(clk), .rst_n(rst_n), .Ve(ve), .Gotejamento(got), .Aspersao(asp),
`ifdef CAIXA_FALHA_SENSOR_EN
    .falha_sel(falha_sel),
`endif
    .Alta(alta), .Media(media), .Baixa(baixa), .nivel(nivel), .estado(estado),
    .transbordo(transbordo), .seco(seco)
  );
  int checks = 0, errors = 0;
  int lvl, st, cyc;
  bit e_tr, e_se;
  bit [2:0] e_sens;
  task automatic check(input string tag, input int got_v, input int exp_v);
    checks++;
    if (got_v != exp_v) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, got_v, exp_v);
    end
  endtask
  task automatic compare();
    check("nivel", int'(nivel), lvl);
    check("estado", int'(estado), st);
    check("transbordo", int'(transbordo), int'(e_tr));
    check("seco", int'(seco), int'(e_se));
    check("sensores", int'({alta, media, baixa}), int'(e_sens));
  endtask
  task automatic model_reset();
    lvl = INIT; st = int'(ESTAVEL); cyc = 0; e_tr = 0; e_se = 0; e_sens = 3'b000;
  endtask
  task automatic model_edge();
    int net, nxt;
    e_sens = {lvl >= 80, lvl >= 50, lvl >= 20};
`ifdef CAIXA_FALHA_SENSOR_EN
    if (falha_sel == 2'b01) e_sens[1] = 1'b0;
    if (falha_sel == 2'b10) e_sens[2] = 1'b1;
    if (falha_sel == 2'b11) e_sens = 3'b000;
`endif
    e_tr = 0; e_se = 0;
    if (cyc % TD == TD - 1) begin
      net = (ve ? 4 : 0) - (got ? 1 : 0) - (asp ? 3 : 0);
      nxt = lvl + net;
      if (nxt > CAP) begin lvl = CAP; e_tr = 1; st = int'(TRANSBORDO); end
      else if (nxt < 0) begin lvl = 0; e_se = 1; st = int'(ESTAVEL); end
      else begin
        lvl = nxt;
        st = net > 0 ? int'(ENCHENDO) : net < 0 ? int'(ESVAZIANDO) : int'(ESTAVEL);
      end
    end
    cyc++;
  endtask
  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      model_edge();
      @(negedge clk);
      compare();
    end
  endtask
  task automatic set_in(input bit v, input bit g, input bit a);
    ve = v; got = g; asp = a;
  endtask
  initial begin
    model_reset();
    @(negedge clk);
    compare();
    rst_n = 1;
    set_in(1, 0, 0); step(300);
    set_in(0, 1, 1); step(300);
    set_in(0, 0, 1); step(40);
    set_in(1, 0, 0); step(150);
    set_in(1, 1, 1); step(60);
    set_in(0, 1, 1); step(40);
    set_in(1, 0, 0);
    for (int i = 0; i < 200 && !(lvl >= 60 && cyc % TD == TD - 3); i++) step(1);
    rst_n = 0;
    model_reset();
    #1 compare();
    @(negedge clk);
    compare();
    rst_n = 1;
    step(120);
`ifdef CAIXA_FALHA_SENSOR_EN
    for (int s = 0; s < 4; s++) begin
      falha_sel = 2'(s);
      step(3);
    end
    falha_sel = 2'b00;
`endif
    for (int i = 0; i < 3000; i++) begin
      if (i % 20 == 0) set_in(1'($urandom_range(0, 2) != 0), 1'($urandom), 1'($urandom));
`ifdef CAIXA_FALHA_SENSOR_EN
      if (i % 97 == 0) falha_sel = 2'($urandom);
`endif
      step(1);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/caixa_agua_planta.md
Name: caixa_agua_planta

Overview:
Behavioural plant model of the water tank and irrigation load. It is the other end of the tank/irrigation controller interface: it consumes the actuator commands (Ve, Gotejamento, Aspersao) and produces the level-sensor signals (Alta, Media, Baixa) that the controller reads. It closes the loop for system-level simulation and FPGA demo builds, replacing physical float switches.

Parameters:
LEVEL_W, 8, width of the internal level register
CAPACITY, 100, maximum level (units)
INIT_LEVEL, 0, level loaded at reset
LOW_TH, 20, Baixa asserts when level >= LOW_TH
MID_TH, 50, Media asserts when level >= MID_TH
HIGH_TH, 80, Alta asserts when level >= HIGH_TH
FILL_RATE, 4, units added per tick while Ve=1
DRIP_RATE, 1, units removed per tick while Gotejamento=1
SPRAY_RATE, 3, units removed per tick while Aspersao=1
TICK_DIV, 10, clk cycles per simulation tick (>=1)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
Ve  in  1  inlet valve command (1 = filling)
Gotejamento  in  1  drip irrigation active
Aspersao  in  1  sprinkler irrigation active
Alta  out  1  high sensor
Media  out  1  mid sensor
Baixa  out  1  low sensor
nivel  out  LEVEL_W  current level
estado  out  2  plant state (see FSM)
transbordo  out  1  one-cycle pulse: overflow on this tick
seco  out  1  one-cycle pulse: demand exceeded available water on this tick

Behaviour:
- Reset (async, rst_n=0): level=INIT_LEVEL; Alta/Media/Baixa=0; estado=ESTAVEL; transbordo=seco=0; prescaler=0.
- Prescaler counts 0..TICK_DIV-1. tick=1 for one clk when count==TICK_DIV-1, then wraps to 0. With TICK_DIV=1, tick=1 every cycle.
- On tick, inputs are sampled that same cycle:
  - add = Ve ? FILL_RATE : 0
  - sub = (Gotejamento ? DRIP_RATE : 0) + (Aspersao ? SPRAY_RATE : 0)
  - next = level + add - sub, computed signed in LEVEL_W+2 bits.
  - next > CAPACITY: level=CAPACITY, transbordo=1 that cycle.
  - next < 0: level=0, seco=1 that cycle.
  - Otherwise level=next.
  - Both pulses are registered and last exactly one clk.
- Non-tick cycles: level, estado and pulses hold (pulses=0).
- Sensors are registered from the level register, one clk latency after a level change:
  - Baixa = level >= LOW_TH
  - Media = level >= MID_TH
  - Alta = level >= HIGH_TH
  - Sensors are monotone; they never show an inconsistent pattern unless the optional feature forces one.
- FSM estado, updated on tick only; the new state depends on the same tick's computation:
  - ESTAVEL=0: net=0, or no clipping state applies.
  - ENCHENDO=1: net>0 and no overflow.
  - ESVAZIANDO=2: net<0 and no seco.
  - TRANSBORDO=3: overflow this tick. Has priority over ENCHENDO. Remains while each subsequent tick still overflows.
  - A seco tick yields ESTAVEL. The level is pinned at 0, so the tank is not "draining".
- Simultaneous Ve and irrigation: the net value is used. Example: Ve+Aspersao gives net +1.
- Reset asserted mid-tick: aborts immediately. The prescaler restarts from 0 after release.
- Parameter legality: LOW_TH <= MID_TH <= HIGH_TH <= CAPACITY < 2^LEVEL_W, and INIT_LEVEL <= CAPACITY. Checked by an elaboration-time assertion.

Optional Feature:
CAIXA_FALHA_SENSOR_EN.
- Defined: adds input falha_sel[1:0].
  - 00 = normal
  - 01 = Media stuck at 0
  - 10 = Alta stuck at 1
  - 11 = all sensors stuck at 0
  - The override is applied on the registered sensor outputs (still 1-clk latency). This produces inconsistent patterns, e.g. Alta=1/Media=0, so the controller's Erro path can be exercised.
- Undefined: port absent; sensors always reflect level.

Decomposition:
- Package caixa_pkg:
  - estado enum (ESTAVEL, ENCHENDO, ESVAZIANDO, TRANSBORDO), 2 bits
  - falha_sel encodings
  - default rate/threshold constants
- Sub-module tick_gen (prescaler, parameter TICK_DIV, outputs tick). Instantiated once.

Test Plan:
1. Reset with INIT_LEVEL=0, Ve=1, others 0, TICK_DIV=10:
   - nivel = 4, 8, … on each tick, rising every 10 clks.
   - Baixa rises 1 clk after nivel=20; Media after 52; Alta after 80.
   - estado=ENCHENDO.
2. Fill continuously from 96:
   - Next tick nivel=100, estado=ENCHENDO.
   - Following tick nivel stays 100, transbordo one-clk pulse, estado=TRANSBORDO.
3. INIT_LEVEL=2, Ve=0, Aspersao=1:
   - Tick 1: nivel=0 and seco pulse, estado=ESTAVEL.
   - Later ticks: seco pulses again, nivel stays 0.
4. nivel=50, Ve=1, Gotejamento=1, Aspersao=1:
   - net 0 every tick, nivel=50, estado=ESTAVEL.
   - Drop Ve: nivel 46, 42…; Media falls 1 clk after nivel=46; estado=ESVAZIANDO.
5. rst_n pulsed low mid-fill at nivel=60, 3 clks before a tick:
   - Outputs clear immediately.
   - After release, first tick occurs exactly TICK_DIV clks later.
6. With CAIXA_FALHA_SENSOR_EN, nivel=30, falha_sel=10:
   - Alta=1, Media=0, Baixa=1 one clk after select.
   - falha_sel=00 restores Alta=0.
